// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 register file and exception sequencer for the 5-stage MIPS core.
// Holds Status/Cause/EPC/BadVAddr/Count/Compare, drives pipeline flush and the
// redirect PC on exception entry or ERET, and services MFC0/MTC0 in the M stage.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] STATUS_RST = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  localparam logic [31:0] CODE_ERET = 32'h0000000E;

  // Bits of each register that an MTC0 may change; zero means read-only or unmapped.
  function automatic logic [31:0] wr_mask(input logic [4:0] addr);
    logic [31:0] m;
    case (addr)
      ADDR_COUNT:   m = 32'hFFFFFFFF;
      ADDR_COMPARE: m = 32'hFFFFFFFF;
      ADDR_EPC:     m = 32'hFFFFFFFF;
      ADDR_STATUS:  m = 32'h0000FF03;
      ADDR_CAUSE:   m = 32'h00000300;
      default:      m = 32'h00000000;
    endcase
    return m;
  endfunction

  // Merge write data into the old register value under the field mask.
  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        timer_q, timer_d;
  logic        tick_q, tick_d;

  logic        exc_s;
  logic        eret_s;
  logic        known_s;
  logic [4:0]  exccode_s;
  logic        wr_en_s;
  logic [31:0] rd_s;

  // Classify the incoming exception code and pick its ExcCode.
  always_comb begin
    exc_s     = (excepttype_i != 32'd0) && (excepttype_i != CODE_ERET);
    eret_s    = (excepttype_i == CODE_ERET);
    known_s   = 1'b1;
    exccode_s = 5'd0;
    case (excepttype_i)
      32'h00000001: exccode_s = 5'd0;
      32'h00000004: exccode_s = 5'd4;
      32'h00000005: exccode_s = 5'd5;
      32'h00000008: exccode_s = 5'd8;
      32'h00000009: exccode_s = 5'd9;
      32'h0000000A: exccode_s = 5'd10;
      32'h0000000C: exccode_s = 5'd12;
      default: begin
        exccode_s = 5'd0;
        known_s   = 1'b0;
      end
    endcase
    // A faulting or returning instruction must not commit its MTC0.
    wr_en_s = we_i && !exc_s && !eret_s;
  end

  // Flush and redirect are produced in the same cycle the M-stage event is seen.
  always_comb begin
    flush_o = 1'b0;
    newpc_o = 32'd0;
    if (eret_s) begin
      flush_o = 1'b1;
      // EPC being written by the same-cycle MTC0 is the freshest return address.
      newpc_o = (we_i && (waddr_i == ADDR_EPC)) ? data_i : epc_q;
    end else if (exc_s && known_s) begin
      flush_o = 1'b1;
      newpc_o = EXC_VECTOR;
    end else begin
      flush_o = 1'b0;
      newpc_o = 32'd0;
    end
  end

  // Next-state for Count, Compare and the timer-pending flag.
  always_comb begin
    tick_d    = ~tick_q;
    count_d   = tick_q ? (count_q + 32'd1) : count_q;
    compare_d = compare_q;
    timer_d   = timer_q;
    if (wr_en_s && (waddr_i == ADDR_COUNT)) begin
      count_d = data_i;
    end else begin
      count_d = count_d;
    end
    if (wr_en_s && (waddr_i == ADDR_COMPARE)) begin
      compare_d = data_i;
      timer_d   = 1'b0;
    end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_d   = 1'b1;
    end else begin
      timer_d   = timer_q;
    end
  end

  // Next-state for Status, Cause, EPC and BadVAddr including exception entry/return.
  always_comb begin
    status_d   = (wr_en_s && (waddr_i == ADDR_STATUS))
                 ? merge(status_q, data_i, wr_mask(ADDR_STATUS)) : status_q;
    cause_d    = (wr_en_s && (waddr_i == ADDR_CAUSE))
                 ? merge(cause_q, data_i, wr_mask(ADDR_CAUSE)) : cause_q;
    epc_d      = (wr_en_s && (waddr_i == ADDR_EPC)) ? data_i : epc_q;
    badvaddr_d = badvaddr_q;
    // Interrupt pending bits track the lines every cycle; IP7 also carries the timer.
    cause_d[15:10] = {int_i[5] | timer_q, int_i[4:0]};
    if (exc_s) begin
      // A nested exception keeps the original return address and BD.
      if (!status_q[1]) begin
        epc_d       = is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        cause_d[31] = is_in_delayslot_i;
      end else begin
        epc_d       = epc_q;
        cause_d[31] = cause_q[31];
      end
      cause_d[6:2] = exccode_s;
      status_d[1]  = 1'b1;
      if ((exccode_s == 5'd4) || (exccode_s == 5'd5)) begin
        badvaddr_d = bad_addr_i;
      end else begin
        badvaddr_d = badvaddr_q;
      end
    end else if (eret_s) begin
      status_d[1] = 1'b0;
    end else begin
      status_d[1] = status_d[1];
    end
  end

  // MFC0 read with same-cycle MTC0 forwarding through the write mask.
  always_comb begin
    case (raddr_i)
      ADDR_BADVADDR: rd_s = badvaddr_q;
      ADDR_COUNT:    rd_s = count_q;
      ADDR_COMPARE:  rd_s = compare_q;
      ADDR_STATUS:   rd_s = status_q;
      ADDR_CAUSE:    rd_s = cause_q;
      ADDR_EPC:      rd_s = epc_q;
      default:       rd_s = 32'd0;
    endcase
    if (we_i && (waddr_i == raddr_i)) begin
      data_o = merge(rd_s, data_i, wr_mask(raddr_i));
    end else begin
      data_o = rd_s;
    end
  end

  // State registers with synchronous reset dominating all other inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RST;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      timer_q    <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      timer_q    <= timer_d;
      tick_q     <= tick_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl using an expectation queue.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
  logic        timer_int_o, flush_o;
  logic [31:0] newpc_o;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
    .data_i(data_i), .int_i(int_i), .excepttype_i(excepttype_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .bad_addr_i(bad_addr_i),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
    .timer_int_o(timer_int_o), .flush_o(flush_o), .newpc_o(newpc_o)
  );

  always #5 clk = ~clk;

  typedef enum int {S_DATA, S_COUNT, S_COMPARE, S_STATUS, S_CAUSE, S_EPC,
                    S_BADV, S_TIMER, S_FLUSH, S_NEWPC} sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic logic [31:0] obs(input sel_e s);
    case (s)
      S_DATA:    return data_o;
      S_COUNT:   return count_o;
      S_COMPARE: return compare_o;
      S_STATUS:  return status_o;
      S_CAUSE:   return cause_o;
      S_EPC:     return epc_o;
      S_BADV:    return badvaddr_o;
      S_TIMER:   return {31'd0, timer_int_o};
      S_FLUSH:   return {31'd0, flush_o};
      S_NEWPC:   return newpc_o;
      default:   return 32'hXXXXXXXX;
    endcase
  endfunction

  task automatic expect_v(input string tag, input sel_e s, input logic [31:0] m,
                          input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sel = s; x.mask = m; x.exp = e;
    q.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    logic [31:0] o;
    while (q.size() > 0) begin
      x = q.pop_front();
      o = obs(x.sel) & x.mask;
      tests_run++;
      assert (o === x.exp) else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; excepttype_i = 32'd0;
    pc_i = 32'd0; is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
  endtask

  localparam logic [31:0] ALL = 32'hFFFFFFFF;

  initial begin
    rst = 1'b1; raddr_i = 5'd0; int_i = 6'd0;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Reset state after 10 idle cycles.
    expect_v("rst_status", S_STATUS, ALL, 32'h00400000);
    expect_v("rst_count", S_COUNT, ALL, 32'd5);
    expect_v("rst_compare", S_COMPARE, ALL, 32'd0);
    expect_v("rst_cause", S_CAUSE, ALL, 32'd0);
    expect_v("rst_epc", S_EPC, ALL, 32'd0);
    expect_v("rst_badv", S_BADV, ALL, 32'd0);
    expect_v("rst_timer", S_TIMER, ALL, 32'd0);
    expect_v("rst_flush", S_FLUSH, ALL, 32'd0);
    expect_v("rst_newpc", S_NEWPC, ALL, 32'd0);
    raddr_i = 5'd12; #1;
    expect_v("mfc0_status", S_DATA, ALL, 32'h00400000);
    check();
    raddr_i = 5'd3; #1;
    expect_v("mfc0_unmapped", S_DATA, ALL, 32'd0);
    check();

    // Timer: Compare=8, wait for Count to reach it.
    we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd8;
    step();
    idle_inputs();
    for (int i = 0; i < 40 && count_o != 32'd8; i++) step();
    expect_v("cnt_reach8", S_COUNT, ALL, 32'd8);
    expect_v("timer_pre", S_TIMER, ALL, 32'd0);
    check();
    step();
    expect_v("timer_set", S_TIMER, ALL, 32'd1);
    expect_v("ip7_lag", S_CAUSE, 32'h00008000, 32'd0);
    check();
    step();
    expect_v("ip7_set", S_CAUSE, 32'h00008000, 32'h00008000);
    expect_v("timer_hold", S_TIMER, ALL, 32'd1);
    check();
    we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd0; raddr_i = 5'd11; #1;
    expect_v("fwd_compare", S_DATA, ALL, 32'd0);
    check();
    step();
    idle_inputs();
    expect_v("timer_clr", S_TIMER, ALL, 32'd0);
    expect_v("compare_0", S_COMPARE, ALL, 32'd0);
    check();
    int_i = 6'b000011;
    step();
    int_i = 6'd0;
    expect_v("ip_sample", S_CAUSE, 32'h0000FC00, 32'h00000C00);
    check();

    // Exception 4 in a delay slot with EXL=0.
    excepttype_i = 32'h4; pc_i = 32'h80001004; is_in_delayslot_i = 1'b1;
    bad_addr_i = 32'h1235; #1;
    expect_v("adel_flush", S_FLUSH, ALL, 32'd1);
    expect_v("adel_newpc", S_NEWPC, ALL, 32'hBFC00380);
    check();
    step();
    idle_inputs();
    expect_v("adel_epc", S_EPC, ALL, 32'h80001000);
    expect_v("adel_bd", S_CAUSE, 32'h80000000, 32'h80000000);
    expect_v("adel_code", S_CAUSE, 32'h0000007C, 32'd4 << 2);
    expect_v("adel_badv", S_BADV, ALL, 32'h1235);
    expect_v("adel_exl", S_STATUS, 32'h2, 32'h2);
    check();

    // Nested syscall with EXL=1.
    excepttype_i = 32'h8; pc_i = 32'h100; #1;
    expect_v("sys_flush", S_FLUSH, ALL, 32'd1);
    expect_v("sys_newpc", S_NEWPC, ALL, 32'hBFC00380);
    check();
    step();
    idle_inputs();
    expect_v("sys_epc_keep", S_EPC, ALL, 32'h80001000);
    expect_v("sys_code", S_CAUSE, 32'h0000007C, 32'd8 << 2);
    expect_v("sys_bd_keep", S_CAUSE, 32'h80000000, 32'h80000000);
    check();

    // ERET returning to a software-written EPC.
    we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h80000200;
    step();
    idle_inputs();
    expect_v("epc_write", S_EPC, ALL, 32'h80000200);
    check();
    excepttype_i = 32'he; #1;
    expect_v("eret_flush", S_FLUSH, ALL, 32'd1);
    expect_v("eret_newpc", S_NEWPC, ALL, 32'h80000200);
    check();
    step();
    idle_inputs();
    expect_v("eret_exl", S_STATUS, 32'h2, 32'd0);
    check();
    excepttype_i = 32'he; we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h300; #1;
    expect_v("eret_fwd_pc", S_NEWPC, ALL, 32'h300);
    check();
    step();
    idle_inputs();
    expect_v("eret_mtc0_drop", S_EPC, ALL, 32'h80000200);
    check();

    // Overflow exception suppresses a simultaneous Status write.
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000FF01;
    excepttype_i = 32'hc; pc_i = 32'h2000; #1;
    expect_v("ov_flush", S_FLUSH, ALL, 32'd1);
    check();
    step();
    idle_inputs();
    expect_v("ov_status", S_STATUS, ALL, 32'h00400002);
    expect_v("ov_code", S_CAUSE, 32'h0000007C, 32'd12 << 2);
    expect_v("ov_epc", S_EPC, ALL, 32'h2000);
    expect_v("ov_bd", S_CAUSE, 32'h80000000, 32'd0);
    check();

    // Plain Status write honours the field mask, including forwarding.
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hFFFFFFFF; raddr_i = 5'd12; #1;
    expect_v("fwd_status", S_DATA, ALL, 32'h0040FF03);
    check();
    step();
    idle_inputs();
    expect_v("status_mask", S_STATUS, ALL, 32'h0040FF03);
    check();

    // Unrecognised nonzero code: no flush, ExcCode 0.
    excepttype_i = 32'h3; #1;
    expect_v("unk_flush", S_FLUSH, ALL, 32'd0);
    expect_v("unk_newpc", S_NEWPC, ALL, 32'd0);
    check();
    step();
    idle_inputs();
    expect_v("unk_code", S_CAUSE, 32'h0000007C, 32'd0);
    check();

    // BadVAddr ignores MTC0; Count load and wrap.
    we_i = 1'b1; waddr_i = 5'd8; data_i = 32'hDEAD;
    step();
    idle_inputs();
    expect_v("badv_ro", S_BADV, ALL, 32'h1235);
    check();
    we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hFFFFFFFF;
    step();
    idle_inputs();
    expect_v("count_load", S_COUNT, ALL, 32'hFFFFFFFF);
    check();
    step(); step();
    expect_v("count_wrap", S_COUNT, ALL, 32'd0);
    check();

    // Reset mid-sequence dominates a concurrent write.
    rst = 1'b1; we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h1234;
    step();
    rst = 1'b0;
    idle_inputs();
    expect_v("rst2_status", S_STATUS, ALL, 32'h00400000);
    expect_v("rst2_count", S_COUNT, ALL, 32'd0);
    expect_v("rst2_cause", S_CAUSE, ALL, 32'd0);
    expect_v("rst2_epc", S_EPC, ALL, 32'd0);
    expect_v("rst2_badv", S_BADV, ALL, 32'd0);
    expect_v("rst2_timer", S_TIMER, ALL, 32'd0);
    check();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
